div_ctrl: RTL and testbench
===========================

DIV_CTRL -- requirements
Module: div_ctrl

Interface
- REQ-001 The block SHALL have no parameters; datapath width is fixed at 32 bits.
- REQ-002 clk  input  1  single clock; all state updates on rising edge.
- REQ-003 rst  input  1  reset, synchronous, active-high (rst=1 sampled on rising edge resets block).
- REQ-004 start_i  input  1  request from EX to divide; held high by EX until ready_o seen.
- REQ-005 annul_i  input  1  abort request (flush); aborts any operation in progress.
- REQ-006 signed_i  input  1  1 = DIV/REM (two's complement), 0 = DIVU/REMU; sampled with start.
- REQ-007 opdata1_i  input  32  dividend; sampled with start.
- REQ-008 opdata2_i  input  32  divisor; sampled with start.
- REQ-009 quot_o  output  32  quotient, registered, valid while ready_o=1.
- REQ-010 rem_o  output  32  remainder, registered, valid while ready_o=1.
- REQ-011 ready_o  output  1  result valid, registered.
- REQ-012 stall_req_o  output  1  pipeline stall request to stall controller, combinational.

Function
- REQ-013 States SHALL be IDLE, BYZERO, ON, END, with a 6-bit iteration counter cnt.
- REQ-014 IDLE, start_i=1, annul_i=0, opdata2_i!=0: latch operands, signed_i, and operand signs; load |dividend| (for signed), or the raw dividend (for unsigned), into a 65-bit shift register; cnt=0; go to ON.
- REQ-015 IDLE, start_i=1, annul_i=0, opdata2_i=0: latch dividend; go to BYZERO.
- REQ-016 IDLE otherwise: stay; ready_o=0; quot_o=rem_o=0.
- REQ-017 BYZERO: next edge go to END with quot_o=0xFFFFFFFF and rem_o=original dividend, for both signed and unsigned.
- REQ-018 ON: each edge performs one restoring shift-subtract step using |divisor| (signed) or the raw divisor (unsigned); cnt increments.
- REQ-019 ON: the step with cnt=31 SHALL be the last step, and the same edge transitions to END.
- REQ-020 Sign fixup on entering END: negate the quotient if the signs differ (signed only); give the remainder the sign of the dividend (signed only).
- REQ-021 Signed overflow (0x80000000 / 0xFFFFFFFF) SHALL yield quot=0x80000000, rem=0 with no special path; the natural algorithm result is required.
- REQ-022 Latency: start sampled at edge E0, ready_o=1 after edge E32 (33 edges); divide-by-zero has ready_o=1 after edge E1.
- REQ-023 END: ready_o=1, outputs held stable; stay while start_i=1.
- REQ-024 END, start_i=0: go to IDLE; ready_o=0 and outputs cleared at the same edge.
- REQ-025 annul_i=1 in BYZERO or ON: next state IDLE, ready_o=0, outputs 0, cnt=0; the partial result is discarded.
- REQ-026 annul_i=1 in IDLE: any start_i is ignored.
- REQ-027 annul_i=1 in END: go to IDLE (the result is dropped).
- REQ-028 stall_req_o=1 when (IDLE and start_i and !annul_i), or in BYZERO, or in ON.
- REQ-029 stall_req_o=0 in END and in all other cases, including every cycle with rst=1.
- REQ-030 Operand inputs SHALL be ignored after the start edge; changes during ON SHALL NOT affect the result.
- REQ-031 Back-to-back operation: a new start is accepted only from IDLE, i.e. at least one cycle after leaving END.

Reset
- REQ-032 rst=1 SHALL force state=IDLE, cnt=0, ready_o=0, quot_o=0, rem_o=0, shift register=0 at the next edge, regardless of state.
- REQ-033 rst has priority over start_i and annul_i.
- REQ-034 Reset mid-operation SHALL abandon the operation; no ready_o pulse follows.

Verification
- REQ-035 Unsigned: start, signed=0, 100 / 7 -> after 33 edges ready_o=1, quot=14, rem=2, stall_req_o low in END.
- REQ-036 Signed: -7 (0xFFFFFFF9) / 2 -> quot=0xFFFFFFFD (-3), rem=0xFFFFFFFF (-1); and 7 / -2 -> quot=-3, rem=1.
- REQ-037 Divide by zero: 0x12345678 / 0, signed and unsigned -> ready_o after 2 edges, quot=0xFFFFFFFF, rem=0x12345678.
- REQ-038 Overflow: signed 0x80000000 / 0xFFFFFFFF -> quot=0x80000000, rem=0; unsigned same operands -> quot=0, rem=0x80000000.
- REQ-039 Annul at cnt=10, then a new start 50 / 5 -> no ready_o from the first operation; second gives quot=10, rem=0 after 33 edges.
- REQ-040 rst asserted at cnt=20, then hold start_i: block restarts from IDLE; ready_o stays 0 until 33 edges after the new start is sampled.

Source files
------------

// File: rtl/div_ctrl.sv
// Iterative 32-bit restoring divider for the EX stage.
// Handles DIV/DIVU/REM/REMU with flush and stall handshake.
module div_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        annul_i,
  input  logic        signed_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  output logic [31:0] quot_o,
  output logic [31:0] rem_o,
  output logic        ready_o,
  output logic        stall_req_o
);

  typedef enum logic [1:0] {
    IDLE,
    BYZERO,
    ON,
    END
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [64:0] sr_q, sr_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] dvd_q, dvd_d;
  logic        sop_q, sop_d;
  logic        s1_q, s1_d;
  logic        s2_q, s2_d;
  logic [31:0] quot_d, rem_d;
  logic        rdy_d;

  logic [31:0] abs1, abs2;
  logic [32:0] diff;
  logic [64:0] sr_step;
  logic [31:0] q_raw, r_raw;
  logic [31:0] q_fix, r_fix;

  assign abs1 = (signed_i && opdata1_i[31])
              ? -opdata1_i : opdata1_i;
  assign abs2 = (signed_i && opdata2_i[31])
              ? -opdata2_i : opdata2_i;

  // sr[63:32] holds the shifted partial remainder
  assign diff    = {1'b0, sr_q[63:32]} - {1'b0, dvs_q};
  assign sr_step = diff[32]
                 ? {sr_q[63:0], 1'b0}
                 : {diff[31:0], sr_q[31:0], 1'b1};
  assign q_raw   = sr_step[31:0];
  assign r_raw   = sr_step[64:33];
  assign q_fix   = (sop_q && (s1_q ^ s2_q)) ? -q_raw : q_raw;
  assign r_fix   = (sop_q && s1_q) ? -r_raw : r_raw;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    dvs_d   = dvs_q;
    dvd_d   = dvd_q;
    sop_d   = sop_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    quot_d  = quot_o;
    rem_d   = rem_o;
    rdy_d   = ready_o;
    stall_req_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        rdy_d  = 1'b0;
        quot_d = '0;
        rem_d  = '0;
        if (start_i && !annul_i) begin
          stall_req_o = 1'b1;
          dvd_d = opdata1_i;
          if (opdata2_i == 32'd0) begin
            state_d = BYZERO;
          end else begin
            sop_d   = signed_i;
            s1_d    = signed_i && opdata1_i[31];
            s2_d    = signed_i && opdata2_i[31];
            dvs_d   = abs2;
            sr_d    = {32'd0, abs1, 1'b0};
            cnt_d   = '0;
            state_d = ON;
          end
        end
      end
      BYZERO: begin
        stall_req_o = 1'b1;
        if (annul_i) begin
          state_d = IDLE;
          cnt_d   = '0;
          rdy_d   = 1'b0;
          quot_d  = '0;
          rem_d   = '0;
        end else begin
          state_d = END;
          rdy_d   = 1'b1;
          quot_d  = 32'hFFFF_FFFF;
          rem_d   = dvd_q;
        end
      end
      ON: begin
        stall_req_o = 1'b1;
        if (annul_i) begin
          state_d = IDLE;
          cnt_d   = '0;
          sr_d    = '0;
          rdy_d   = 1'b0;
          quot_d  = '0;
          rem_d   = '0;
        end else begin
          sr_d  = sr_step;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            state_d = END;
            rdy_d   = 1'b1;
            quot_d  = q_fix;
            rem_d   = r_fix;
          end
        end
      end
      END: begin
        if (annul_i || !start_i) begin
          state_d = IDLE;
          cnt_d   = '0;
          rdy_d   = 1'b0;
          quot_d  = '0;
          rem_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst) stall_req_o = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      dvs_q   <= '0;
      dvd_q   <= '0;
      sop_q   <= 1'b0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      quot_o  <= '0;
      rem_o   <= '0;
      ready_o <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      dvs_q   <= dvs_d;
      dvd_q   <= dvd_d;
      sop_q   <= sop_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      quot_o  <= quot_d;
      rem_o   <= rem_d;
      ready_o <= rdy_d;
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Scoreboard bench for div_ctrl.
// Reference results come from a behavioural RISC-V divide model.
module tb_div_ctrl;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        annul_i;
  logic        signed_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic [31:0] quot_o;
  logic [31:0] rem_o;
  logic        ready_o;
  logic        stall_req_o;

  int checks;
  int failures;
  logic [63:0] sb[$];
  logic [63:0] last;

  div_ctrl dut (
    .clk(clk),
    .rst(rst),
    .start_i(start_i),
    .annul_i(annul_i),
    .signed_i(signed_i),
    .opdata1_i(opdata1_i),
    .opdata2_i(opdata2_i),
    .quot_o(quot_o),
    .rem_o(rem_o),
    .ready_o(ready_o),
    .stall_req_o(stall_req_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input bit s,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!s) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end
    return {q, r};
  endfunction

  task automatic wait_ready(input int lat);
    int n;
    logic [63:0] e;
    n = 0;
    while (!ready_o && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        opdata1_i = $urandom;
        opdata2_i = $urandom;
        signed_i  = ~signed_i;
      end
    end
    e = sb.pop_front();
    last = e;
    if (!ready_o) begin
      chk("timeout", 32'(n), 32'(lat));
    end else begin
      chk("latency", 32'(n), 32'(lat));
      chk("quot", quot_o, e[63:32]);
      chk("rem", rem_o, e[31:0]);
      chk("stall_end", {31'd0, stall_req_o}, 32'd0);
    end
  endtask

  task automatic do_op(input bit s,
                       input logic [31:0] a,
                       input logic [31:0] b);
    @(negedge clk);
    start_i   = 1'b1;
    signed_i  = s;
    opdata1_i = a;
    opdata2_i = b;
    sb.push_back(model(s, a, b));
    #1;
    chk("stall_start", {31'd0, stall_req_o}, 32'd1);
    wait_ready(b == 32'd0 ? 2 : 33);
    @(negedge clk);
    chk("hold_rdy", {31'd0, ready_o}, 32'd1);
    chk("hold_quot", quot_o, last[63:32]);
    chk("hold_rem", rem_o, last[31:0]);
    start_i = 1'b0;
    @(negedge clk);
    chk("clr_rdy", {31'd0, ready_o}, 32'd0);
    chk("clr_quot", quot_o, 32'd0);
    chk("clr_rem", rem_o, 32'd0);
  endtask

  logic [31:0] ta[7] = '{32'd100, 32'hFFFF_FFF9, 32'd7,
                         32'h1234_5678, 32'h1234_5678,
                         32'h8000_0000, 32'h8000_0000};
  logic [31:0] tb[7] = '{32'd7, 32'd2, 32'hFFFF_FFFE,
                         32'd0, 32'd0,
                         32'hFFFF_FFFF, 32'hFFFF_FFFF};
  bit ts[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    start_i   = 1'b0;
    annul_i   = 1'b0;
    signed_i  = 1'b0;
    opdata1_i = '0;
    opdata2_i = '0;
    repeat (2) @(negedge clk);
    start_i = 1'b1;
    #1;
    chk("rst_stall", {31'd0, stall_req_o}, 32'd0);
    chk("rst_rdy", {31'd0, ready_o}, 32'd0);
    chk("rst_quot", quot_o, 32'd0);
    chk("rst_rem", rem_o, 32'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) do_op(ts[i], ta[i], tb[i]);
    for (int i = 0; i < 4; i++)
      do_op(1'(i), $urandom, $urandom_range(1, 1000));

    // annul in IDLE: start must be ignored
    @(negedge clk);
    start_i = 1'b1;
    annul_i = 1'b1;
    opdata1_i = 32'd9;
    opdata2_i = 32'd3;
    #1;
    chk("annul_idle_stall", {31'd0, stall_req_o}, 32'd0);
    repeat (3) @(negedge clk);
    chk("annul_idle_rdy", {31'd0, ready_o}, 32'd0);
    start_i = 1'b0;
    annul_i = 1'b0;

    // annul mid-operation at cnt=10
    @(negedge clk);
    start_i   = 1'b1;
    signed_i  = 1'b0;
    opdata1_i = 32'd1000;
    opdata2_i = 32'd3;
    repeat (11) @(negedge clk);
    annul_i = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    annul_i = 1'b0;
    chk("annul_on_stall", {31'd0, stall_req_o}, 32'd0);
    repeat (40) begin
      @(negedge clk);
      if (ready_o) chk("annul_on_rdy", 32'd1, 32'd0);
    end
    chk("annul_on_quot", quot_o, 32'd0);
    do_op(1'b0, 32'd50, 32'd5);

    // reset at cnt=20 with start held
    @(negedge clk);
    start_i   = 1'b1;
    signed_i  = 1'b1;
    opdata1_i = 32'hFFFF_FF00;
    opdata2_i = 32'd7;
    repeat (21) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_on_stall", {31'd0, stall_req_o}, 32'd0);
    @(negedge clk);
    chk("rst_on_rdy", {31'd0, ready_o}, 32'd0);
    signed_i  = 1'b0;
    opdata1_i = 32'd77;
    opdata2_i = 32'd10;
    rst = 1'b0;
    sb.push_back(model(1'b0, 32'd77, 32'd10));
    wait_ready(33);

    // annul while in END drops the result
    annul_i = 1'b1;
    @(negedge clk);
    chk("annul_end_rdy", {31'd0, ready_o}, 32'd0);
    chk("annul_end_quot", quot_o, 32'd0);
    annul_i = 1'b0;
    start_i = 1'b0;
    @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
